gmii_rx_deframer: RTL and testbench



---
 rtl/gmii_rx_deframer_if.sv | 23 ++
 rtl/gmii_rx_deframer.sv | 140 ++++++++++++++
 tb/tb_gmii_rx_deframer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/gmii_rx_deframer_if.sv
// gmii_rx_deframer_if: GMII receive input, AXI-Stream payload output and frame statistics.
interface gmii_rx_deframer_if;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tlast;
    logic       m_axis_tuser;
    logic       stat_frame_good;
    logic       stat_frame_bad;
    logic       stat_crc_err;
    modport master (
        output gmii_rxd, gmii_rx_dv, gmii_rx_er,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        input  stat_frame_good, stat_frame_bad, stat_crc_err
    );
    modport slave (
        input  gmii_rxd, gmii_rx_dv, gmii_rx_er,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        output stat_frame_good, stat_frame_bad, stat_crc_err
    );
endinterface

// File: rtl/gmii_rx_deframer.sv
// gmii_rx_deframer: strips preamble/SFD, checks and removes the FCS, emits payload as AXI-Stream.
module gmii_rx_deframer #(
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518,
    parameter int MAX_PREAMBLE  = 15
) (
    input logic              gmii_rx_clk,
    input logic              reset_n,
    gmii_rx_deframer_if.slave io
);
    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DROP} state_t;
    localparam logic [15:0] MIN_L  = 16'(MIN_FRAME_LEN);
    localparam logic [15:0] MAX_L  = 16'(MAX_FRAME_LEN);
    localparam logic [15:0] OVER_L = 16'(MAX_FRAME_LEN + 1);
    localparam logic [4:0]  PRE_L  = 5'(MAX_PREAMBLE);
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    state_t            state, state_d;
    logic [4:0]        pre, pre_d;
    logic [31:0]       crc, crc_d;
    logic [15:0]       cnt, cnt_d;
    logic              err, err_d;
    logic [3:0][7:0]   dl, dl_d;
    logic [7:0]        p, p_d;
    logic [7:0]        tdata, tdata_d;
    logic              tvalid, tvalid_d, tlast, tlast_d, tuser, tuser_d;
    logic              good, good_d, bad, bad_d, crc_err, crc_err_d;
    logic              crc_ok, bad_frame;

    assign crc_ok    = crc == RESIDUE;
    assign bad_frame = !crc_ok || err || cnt < MIN_L || cnt > MAX_L || cnt < 16'd5;

    always_comb begin
        state_d   = state;
        pre_d     = pre;
        crc_d     = crc;
        cnt_d     = cnt;
        err_d     = err;
        dl_d      = dl;
        p_d       = p;
        tdata_d   = p;
        tvalid_d  = 1'b0;
        tlast_d   = 1'b0;
        tuser_d   = 1'b0;
        good_d    = 1'b0;
        bad_d     = 1'b0;
        crc_err_d = 1'b0;
        case (state)
            IDLE: if (io.gmii_rx_dv) begin
                state_d = io.gmii_rxd == 8'h55 ? PREAMBLE : DROP;
                pre_d   = 5'd1;
            end
            PREAMBLE: if (!io.gmii_rx_dv) state_d = IDLE;
            else if (io.gmii_rxd == 8'h55) begin
                pre_d   = pre + 5'd1;
                state_d = pre + 5'd1 > PRE_L ? DROP : PREAMBLE;
            end else if (io.gmii_rxd == 8'hD5) begin
                state_d = PAYLOAD;
                crc_d   = '1;
                cnt_d   = '0;
                err_d   = 1'b0;
                dl_d    = '0;
                p_d     = '0;
            end else state_d = DROP;
            PAYLOAD: if (!io.gmii_rx_dv) begin
                // P holds the last payload byte only once five bytes have arrived
                state_d   = IDLE;
                tvalid_d  = cnt >= 16'd5;
                tlast_d   = cnt >= 16'd5;
                tuser_d   = cnt >= 16'd5 && bad_frame;
                good_d    = !bad_frame;
                bad_d     = bad_frame;
                crc_err_d = !crc_ok;
            end else if (cnt == OVER_L) begin
                state_d  = DROP;
                tvalid_d = 1'b1;
                tlast_d  = 1'b1;
                tuser_d  = 1'b1;
                bad_d    = 1'b1;
            end else begin
                crc_d    = crc_byte(crc, io.gmii_rxd);
                cnt_d    = cnt == 16'hFFFF ? cnt : cnt + 16'd1;
                dl_d     = {dl[2:0], io.gmii_rxd};
                p_d      = dl[3];
                tvalid_d = cnt >= 16'd5;
                err_d    = err | io.gmii_rx_er;
            end
            default: if (!io.gmii_rx_dv) state_d = IDLE;
        endcase
    end

    always_ff @(posedge gmii_rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= DROP;
            pre     <= '0;
            crc     <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            dl      <= '0;
            p       <= '0;
            tdata   <= '0;
            tvalid  <= 1'b0;
            tlast   <= 1'b0;
            tuser   <= 1'b0;
            good    <= 1'b0;
            bad     <= 1'b0;
            crc_err <= 1'b0;
        end else begin
            state   <= state_d;
            pre     <= pre_d;
            crc     <= crc_d;
            cnt     <= cnt_d;
            err     <= err_d;
            dl      <= dl_d;
            p       <= p_d;
            tdata   <= tdata_d;
            tvalid  <= tvalid_d;
            tlast   <= tlast_d;
            tuser   <= tuser_d;
            good    <= good_d;
            bad     <= bad_d;
            crc_err <= crc_err_d;
        end
    end

    assign io.m_axis_tdata    = tdata;
    assign io.m_axis_tvalid   = tvalid;
    assign io.m_axis_tlast    = tlast;
    assign io.m_axis_tuser    = tuser;
    assign io.stat_frame_good = good;
    assign io.stat_frame_bad  = bad;
    assign io.stat_crc_err    = crc_err;
endmodule

// File: tb/tb_gmii_rx_deframer.sv
// tb_gmii_rx_deframer: directed GMII frames; expected beats and stat pulses are queued and checked by a monitor.
module tb_gmii_rx_deframer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #4 clk = ~clk;

    gmii_rx_deframer_if io();
    gmii_rx_deframer #(.MIN_FRAME_LEN(64), .MAX_FRAME_LEN(1518), .MAX_PREAMBLE(15)) dut (
        .gmii_rx_clk(clk),
        .reset_n(rst_n),
        .io(io)
    );

    typedef struct packed {logic [7:0] d; logic l; logic u;} beat_t;
    beat_t      exp_q[$];
    logic [2:0] stat_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat_t0 = -1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int k = 0; k < 8; k++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    task automatic put(input logic [7:0] d, input logic dv, input logic er);
        @(negedge clk);
        io.gmii_rxd   = d;
        io.gmii_rx_dv = dv;
        io.gmii_rx_er = er;
    endtask

    task automatic exp_beats(input int n, input logic u);
        for (int i = 0; i < n; i++) exp_q.push_back('{8'(i), i == n - 1, u});
    endtask

    task automatic chk_zero(input string nm);
        logic [13:0] v;
        v = {io.m_axis_tdata, io.m_axis_tvalid, io.m_axis_tlast, io.m_axis_tuser,
             io.stat_frame_good, io.stat_frame_bad, io.stat_crc_err};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL %s: outputs %h, required 0", nm, v);
        end
    endtask

    task automatic send(input int npay, input bit bad_fcs, input int er_at, input int rst_at, input bit lat);
        logic [7:0]  fr[$];
        logic [31:0] c;
        c = '1;
        for (int i = 0; i < npay; i++) begin
            fr.push_back(8'(i));
            c = crc_upd(c, 8'(i));
        end
        c = ~c;
        for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
        if (bad_fcs) fr[npay] ^= 8'h01;
        for (int i = 0; i < 7; i++) put(8'h55, 1'b1, 1'b0);
        put(8'hD5, 1'b1, 1'b0);
        foreach (fr[i]) begin
            put(fr[i], 1'b1, i == er_at);
            if (i == 0 && lat) lat_t0 = cyc + 1;
            if (i == rst_at) #1 rst_n = 1'b0;
            if (i == rst_at + 3) begin
                chk_zero("in_reset");
                rst_n = 1'b1;
            end
        end
        put(8'h00, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        beat_t e;
        logic [2:0] s, es;
        if (io.m_axis_tvalid) begin
            if (lat_t0 >= 0) begin
                checks++;
                if (cyc - lat_t0 != 5) begin
                    errors++;
                    $display("FAIL latency: first beat %0d cycles after byte 0, required 5", cyc - lat_t0);
                end
                lat_t0 = -1;
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat: unexpected data %h last %b user %b", io.m_axis_tdata, io.m_axis_tlast, io.m_axis_tuser);
            end else begin
                e = exp_q.pop_front();
                if (io.m_axis_tdata !== e.d || io.m_axis_tlast !== e.l || (e.l && io.m_axis_tuser !== e.u)) begin
                    errors++;
                    $display("FAIL beat: got d=%h l=%b u=%b, required d=%h l=%b u=%b",
                             io.m_axis_tdata, io.m_axis_tlast, io.m_axis_tuser, e.d, e.l, e.u);
                end
            end
            if (io.m_axis_tlast) begin
                checks++;
                if (!(io.stat_frame_good || io.stat_frame_bad)) begin
                    errors++;
                    $display("FAIL stat_align: no good/bad pulse on tlast beat, required one");
                end
            end
        end
        s = {io.stat_frame_good, io.stat_frame_bad, io.stat_crc_err};
        if (s != 3'b000) begin
            checks++;
            if (stat_q.size() == 0) begin
                errors++;
                $display("FAIL stat: unexpected good/bad/crc %b", s);
            end else begin
                es = stat_q.pop_front();
                if (s !== es) begin
                    errors++;
                    $display("FAIL stat: good/bad/crc %b, required %b", s, es);
                end
            end
        end
    end

    initial begin
        io.gmii_rxd   = 8'h00;
        io.gmii_rx_dv = 1'b0;
        io.gmii_rx_er = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (3) put(8'h00, 1'b0, 1'b0);
        // good frame with latency check
        exp_beats(60, 1'b0); stat_q.push_back(3'b100);
        send(60, 1'b0, -1, -1, 1'b1);
        // corrupted FCS
        exp_beats(60, 1'b1); stat_q.push_back(3'b011);
        send(60, 1'b1, -1, -1, 1'b0);
        // receive error on payload byte 10, FCS correct
        exp_beats(60, 1'b1); stat_q.push_back(3'b010);
        send(60, 1'b0, 10, -1, 1'b0);
        // malformed preamble: nothing at all
        put(8'h55, 1'b1, 1'b0); put(8'h55, 1'b1, 1'b0); put(8'hA5, 1'b1, 1'b0); put(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) put(8'(i), 1'b1, 1'b0);
        put(8'h00, 1'b0, 1'b0);
        // runt of three bytes after SFD
        stat_q.push_back(3'b011);
        for (int i = 0; i < 7; i++) put(8'h55, 1'b1, 1'b0);
        put(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) put(8'(i), 1'b1, 1'b0);
        put(8'h00, 1'b0, 1'b0);
        // 40-byte frame with good FCS is undersize
        exp_beats(36, 1'b1); stat_q.push_back(3'b010);
        send(36, 1'b0, -1, -1, 1'b0);
        // 1600-byte frame truncated at 1515 beats, then a good frame after one idle cycle
        exp_beats(1515, 1'b1); stat_q.push_back(3'b010);
        send(1596, 1'b0, -1, -1, 1'b0);
        exp_beats(60, 1'b0); stat_q.push_back(3'b100);
        send(60, 1'b0, -1, -1, 1'b0);
        // reset at payload byte 20: bytes 0..14 already out, no tlast, then a good frame
        for (int i = 0; i < 15; i++) exp_q.push_back('{8'(i), 1'b0, 1'b0});
        send(60, 1'b0, -1, 20, 1'b0);
        exp_beats(60, 1'b0); stat_q.push_back(3'b100);
        send(60, 1'b0, -1, -1, 1'b0);
        repeat (20) put(8'h00, 1'b0, 1'b0);
        checks++;
        if (exp_q.size() != 0 || stat_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats and %0d stats outstanding, required 0", exp_q.size(), stat_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
